// File: rtl/fme_half_sel_if.sv
// rtl/fme_half_sel_if.sv - beat, status and result signals of the half-pel candidate selector
interface fme_half_sel_if #(
    parameter int PIX_W = 8,
    parameter int SAD_W = 12
);
    logic               start;
    logic               valid;
    logic               ready;
    logic [PIX_W-1:0]   cur_pix;
    logic [9*PIX_W-1:0] cand_pix;
    logic               busy;
    logic [3:0]         best;
    logic [SAD_W-1:0]   best_sad;
    logic               en;

    modport master (
        output start, valid, cur_pix, cand_pix,
        input  ready, busy, best, best_sad, en
    );

    modport slave (
        input  start, valid, cur_pix, cand_pix,
        output ready, busy, best, best_sad, en
    );
endinterface

// File: rtl/fme_half_sel.sv
// rtl/fme_half_sel.sv - nine-way half-pel SAD accumulator and minimum-cost selector
// Optional FME_SEL_CENTER_BIAS_EN adds a +4 cost penalty to every non-centre candidate.
module fme_half_sel #(
    parameter int PIX_W   = 8,
    parameter int BLK_PIX = 16,
    parameter int SAD_W   = PIX_W + $clog2(BLK_PIX)
) (
    input  logic          clk,
    input  logic          rst_n,
    fme_half_sel_if.slave bus
);
    localparam int CNT_W = $clog2(BLK_PIX) + 1;
    localparam int CST_W = SAD_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_CMP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [SAD_W-1:0]   acc_q [9];
    logic [CNT_W-1:0]   beat_q;
    logic [3:0]         cidx_q;
    logic [3:0]         run_best_q;
    logic [CST_W-1:0]   run_cost_q;
    logic [3:0]         best_q;
    logic [SAD_W-1:0]   best_sad_q;

    logic               fire, last_beat, cmp_last, take;
    logic [PIX_W-1:0]   diff [9];
    logic [3:0]         cand_k, win_best;
    logic [CST_W-1:0]   cand_cost, win_cost;

    assign fire      = (state_q == S_ACC) && bus.valid;
    assign last_beat = fire && (beat_q == CNT_W'(BLK_PIX - 1));
    assign cmp_last  = (state_q == S_CMP) && (cidx_q == 4'd8);

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            if (bus.cur_pix > bus.cand_pix[k*PIX_W +: PIX_W])
                diff[k] = bus.cur_pix - bus.cand_pix[k*PIX_W +: PIX_W];
            else
                diff[k] = bus.cand_pix[k*PIX_W +: PIX_W] - bus.cur_pix;
        end
    end

    // c=0 seeds with the centre; c=1..8 walk 0,1,2,3,5,6,7,8 so ties stay with the earlier entry
    always_comb begin
        cand_k = 4'd4;
        if (cidx_q == 4'd0)
            cand_k = 4'd4;
        else if (cidx_q <= 4'd4)
            cand_k = cidx_q - 4'd1;
        else
            cand_k = cidx_q;
        cand_cost = {1'b0, acc_q[cand_k]};
`ifdef FME_SEL_CENTER_BIAS_EN
        if (cand_k != 4'd4)
            cand_cost = cand_cost + CST_W'(4);
`endif
        take     = (cidx_q == 4'd0) || (cand_cost < run_cost_q);
        win_best = take ? cand_k : run_best_q;
        win_cost = take ? cand_cost : run_cost_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ACC;
            S_ACC:   if (last_beat) state_d = S_CMP;
            S_CMP:   if (cmp_last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready    = (state_q == S_ACC);
        bus.busy     = (state_q != S_IDLE);
        bus.en       = (state_q == S_DONE);
        bus.best     = best_q;
        bus.best_sad = best_sad_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) acc_q[k] <= '0;
            beat_q     <= '0;
            cidx_q     <= '0;
            run_best_q <= 4'd4;
            run_cost_q <= '0;
            best_q     <= 4'd4;
            best_sad_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < 9; k++) acc_q[k] <= '0;
                        beat_q <= '0;
                        cidx_q <= '0;
                    end
                end
                S_ACC: begin
                    if (fire) begin
                        for (int k = 0; k < 9; k++)
                            acc_q[k] <= acc_q[k] + SAD_W'(diff[k]);
                        beat_q <= beat_q + CNT_W'(1);
                    end
                end
                S_CMP: begin
                    run_best_q <= win_best;
                    run_cost_q <= win_cost;
                    cidx_q     <= cidx_q + 4'd1;
                    // Result registers load on the last compare so they are valid with en
                    if (cmp_last) begin
                        best_q     <= win_best;
                        best_sad_q <= acc_q[win_best];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
